// File: rtl/dec_pkg.sv
// Shared definitions for the decryption round stages: block sizes, round count,
// the beat record carried through the pipeline and the pLayer index helper.
package dec_pkg;

    localparam int SIZE_64    = 64;
    localparam int SIZE_128   = 128;
    localparam int DEC_ROUNDS = 31;
    localparam int DEC_RW     = $clog2(DEC_ROUNDS + 1);

    // Widest-case beat record; stages with a narrower block keep their own
    // width-matched copy of the same layout.
    typedef struct packed {
        logic [SIZE_128-1:0] state;
        logic [DEC_RW-1:0]   round;
        logic                last;
    } dec_beat_t;

    // Source bit feeding output bit i of the inverse pLayer. The inverse
    // permutation reads x at the forward pLayer position P(i).
    function automatic int inv_perm_idx(input int i, input int size);
        if (i == size - 1) begin
            return size - 1;
        end
        return (i * (size / 4)) % (size - 1);
    endfunction

endpackage

// File: rtl/inv_player.sv
// Combinational inverse bit permutation (inverse pLayer). Pure wiring.
module inv_player
    import dec_pkg::*;
#(
    parameter int SIZE = SIZE_64
) (
    input  logic [SIZE-1:0] in_bits,
    output logic [SIZE-1:0] out_bits
);

    // Each output bit is a fixed wire from one input bit.
    for (genvar gi = 0; gi < SIZE; gi++) begin : g_bit
        assign out_bits[gi] = in_bits[inv_perm_idx(gi, SIZE)];
    end

endmodule

// File: rtl/inv_perm_key_stage.sv
// Decryption round stage: key XOR, inverse pLayer, round tagging and a
// two-entry skid buffer toward the inverse S-box layer.
module inv_perm_key_stage
    import dec_pkg::*;
#(
    parameter  int SIZE   = SIZE_64,
    parameter  int ROUNDS = DEC_ROUNDS,
    localparam int RW     = $clog2(ROUNDS + 1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            in_first,
    input  logic [SIZE-1:0] in_state,
    input  logic [SIZE-1:0] in_key,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [SIZE-1:0] out_state,
    output logic [RW-1:0]   out_round,
    output logic            out_last,
    output logic            seq_err
);

    localparam logic [RW-1:0] ROUNDS_TAG = RW'(ROUNDS);
    localparam logic [RW-1:0] ROUNDS_NXT = RW'(ROUNDS - 1);

    typedef struct packed {
        logic [SIZE-1:0] state;
        logic [RW-1:0]   round;
        logic            last;
    } beat_t;

    beat_t           main_q, main_d;
    beat_t           skid_q, skid_d;
    logic            main_vld_q, main_vld_d;
    logic            skid_vld_q, skid_vld_d;
    logic [RW-1:0]   cnt_q, cnt_d;
    logic            seq_err_q, seq_err_d;

    logic [SIZE-1:0] perm_state;
    logic [RW-1:0]   tag;
    beat_t           new_beat;
    logic            accept;
    logic            consume;

    inv_player #(.SIZE(SIZE)) u_inv_player (
        .in_bits  (in_state ^ in_key),
        .out_bits (perm_state)
    );

    // in_ready comes straight from the skid-full flop, so it is registered.
    assign in_ready = ~skid_vld_q;
    assign accept   = in_valid & in_ready;
    assign consume  = main_vld_q & out_ready;

    // Round tagging and countdown; a beat with no block in progress is tagged 0.
    always_comb begin
        cnt_d     = cnt_q;
        seq_err_d = seq_err_q;
        tag       = in_first ? ROUNDS_TAG : cnt_q;
        if (accept) begin
            if (in_first) begin
                cnt_d = ROUNDS_NXT;
            end else if (cnt_q != '0) begin
                cnt_d = cnt_q - 1'b1;
            end else begin
                seq_err_d = 1'b1;
            end
        end
        new_beat.state = perm_state;
        new_beat.round = tag;
        new_beat.last  = (tag == RW'(1));
    end

    // Skid buffer: the output register holds while stalled; an extra beat
    // parks in the skid slot and moves forward when the output drains.
    always_comb begin
        main_d     = main_q;
        skid_d     = skid_q;
        main_vld_d = main_vld_q;
        skid_vld_d = skid_vld_q;
        if (skid_vld_q) begin
            if (consume) begin
                main_d     = skid_q;
                skid_vld_d = 1'b0;
            end
        end else if (accept) begin
            if (!main_vld_q || consume) begin
                main_d     = new_beat;
                main_vld_d = 1'b1;
            end else begin
                skid_d     = new_beat;
                skid_vld_d = 1'b1;
            end
        end else if (consume) begin
            main_vld_d = 1'b0;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            main_q     <= '0;
            skid_q     <= '0;
            main_vld_q <= 1'b0;
            skid_vld_q <= 1'b0;
            cnt_q      <= '0;
            seq_err_q  <= 1'b0;
        end else begin
            main_q     <= main_d;
            skid_q     <= skid_d;
            main_vld_q <= main_vld_d;
            skid_vld_q <= skid_vld_d;
            cnt_q      <= cnt_d;
            seq_err_q  <= seq_err_d;
        end
    end

    assign out_valid = main_vld_q;
    assign out_state = main_q.state;
    assign out_round = main_q.round;
    assign out_last  = main_q.last;
    assign seq_err   = seq_err_q;

endmodule

// File: tb/tb_inv_perm_key_stage.sv
// Directed bench for inv_perm_key_stage at SIZE=64 and SIZE=128.
module tb_inv_perm_key_stage;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    // 64-bit instance signals
    logic        in_valid64, in_ready64, in_first64, out_valid64, out_ready64;
    logic        out_last64, seq_err64;
    logic [63:0] in_state64, in_key64, out_state64;
    logic [4:0]  out_round64;

    // 128-bit instance signals
    logic         in_valid128, in_ready128, in_first128, out_valid128, out_ready128;
    logic         out_last128, seq_err128;
    logic [127:0] in_state128, in_key128, out_state128;
    logic [4:0]   out_round128;

    inv_perm_key_stage #(.SIZE(64), .ROUNDS(31)) dut64 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid64), .in_ready(in_ready64), .in_first(in_first64),
        .in_state(in_state64), .in_key(in_key64),
        .out_valid(out_valid64), .out_ready(out_ready64), .out_state(out_state64),
        .out_round(out_round64), .out_last(out_last64), .seq_err(seq_err64)
    );

    inv_perm_key_stage #(.SIZE(128), .ROUNDS(31)) dut128 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid128), .in_ready(in_ready128), .in_first(in_first128),
        .in_state(in_state128), .in_key(in_key128),
        .out_valid(out_valid128), .out_ready(out_ready128), .out_state(out_state128),
        .out_round(out_round128), .out_last(out_last128), .seq_err(seq_err128)
    );

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive64(input logic v, input logic f, input logic [63:0] s, input logic [63:0] k);
        in_valid64 = v; in_first64 = f; in_state64 = s; in_key64 = k;
    endtask

    task automatic drive128(input logic v, input logic f, input logic [127:0] s, input logic [127:0] k);
        in_valid128 = v; in_first128 = f; in_state128 = s; in_key128 = k;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        compared++;
        if ({in_ready64, out_valid64, out_round64, out_last64, seq_err64} !== {1'b1, 1'b0, 5'd0, 1'b0, 1'b0}) begin
            mismatched++;
            $display("FAIL reset_ctrl64 got rdy=%b vld=%b rnd=%0d last=%b err=%b want 1 0 0 0 0",
                     in_ready64, out_valid64, out_round64, out_last64, seq_err64);
        end
        compared++;
        if (out_state64 !== 64'h0) begin
            mismatched++;
            $display("FAIL reset_state64 got %h want 0", out_state64);
        end
        compared++;
        if ({in_ready128, out_valid128, out_round128, out_last128, seq_err128, out_state128} !==
            {1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 128'h0}) begin
            mismatched++;
            $display("FAIL reset_all128 got rdy=%b vld=%b rnd=%0d last=%b err=%b st=%h want 1 0 0 0 0 0",
                     in_ready128, out_valid128, out_round128, out_last128, seq_err128, out_state128);
        end
        $display("reset: done");
    endtask

    // Scenario 1: single bit 16 lands on output bit 1, with 1-cycle latency.
    task automatic test_single64();
        out_ready64 = 1'b1;
        drive64(1'b1, 1'b1, 64'h0000_0000_0001_0000, 64'h0);
        compared++;
        if (out_valid64 !== 1'b0) begin
            mismatched++;
            $display("FAIL single64_pre_valid got %b want 0", out_valid64);
        end
        step();
        drive64(1'b0, 1'b0, 64'h0, 64'h0);
        compared++;
        if ({out_valid64, out_state64, out_round64, out_last64} !== {1'b1, 64'h0000_0000_0000_0002, 5'd31, 1'b0}) begin
            mismatched++;
            $display("FAIL single64 got vld=%b st=%h rnd=%0d last=%b want 1 0000000000000002 31 0",
                     out_valid64, out_state64, out_round64, out_last64);
        end
        $display("single64: st=%h rnd=%0d", out_state64, out_round64);
        step();
        compared++;
        if (out_valid64 !== 1'b0) begin
            mismatched++;
            $display("FAIL single64_drain got vld=%b want 0", out_valid64);
        end
    endtask

    // Scenario 2: key-only all ones, and the fixed top bit; back to back.
    task automatic test_datapath64();
        out_ready64 = 1'b1;
        drive64(1'b1, 1'b1, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF);
        step();
        drive64(1'b1, 1'b1, 64'h8000_0000_0000_0000, 64'h0);
        compared++;
        if ({out_valid64, out_state64} !== {1'b1, 64'hFFFF_FFFF_FFFF_FFFF}) begin
            mismatched++;
            $display("FAIL datapath64_ones got vld=%b st=%h want 1 ffffffffffffffff", out_valid64, out_state64);
        end
        $display("datapath64 ones: st=%h", out_state64);
        step();
        drive64(1'b1, 1'b1, 64'h0000_0000_0000_0004, 64'h0);
        compared++;
        if ({out_valid64, out_state64} !== {1'b1, 64'h8000_0000_0000_0000}) begin
            mismatched++;
            $display("FAIL datapath64_bit63 got vld=%b st=%h want 1 8000000000000000", out_valid64, out_state64);
        end
        $display("datapath64 bit63: st=%h", out_state64);
        step();
        drive64(1'b0, 1'b0, 64'h0, 64'h0);
        // x bit 2 appears at output bit 8
        compared++;
        if (out_state64 !== 64'h0000_0000_0000_0100) begin
            mismatched++;
            $display("FAIL datapath64_bit2 got st=%h want 0000000000000100", out_state64);
        end
        $display("datapath64 bit2: st=%h", out_state64);
        step();
    endtask

    // Scenario 3: a full block of 31 rounds without bubbles.
    task automatic test_back_to_back64();
        out_ready64 = 1'b1;
        for (int k = 0; k < 31; k++) begin
            drive64(1'b1, (k == 0), 64'h0, 64'h2);
            step();
            compared++;
            if ({out_valid64, in_ready64, out_round64, out_last64, out_state64} !==
                {1'b1, 1'b1, 5'(31 - k), (k == 30), 64'h10}) begin
                mismatched++;
                $display("FAIL b2b64 beat %0d got vld=%b rdy=%b rnd=%0d last=%b st=%h want 1 1 %0d %b 10",
                         k, out_valid64, in_ready64, out_round64, out_last64, out_state64, 31 - k, (k == 30));
            end
            $display("b2b64 beat %0d: rnd=%0d last=%b", k, out_round64, out_last64);
        end
        drive64(1'b0, 1'b0, 64'h0, 64'h0);
    endtask

    // Scenario 5a: beat past the end of the block.
    task automatic test_seq_err64();
        out_ready64 = 1'b1;
        drive64(1'b1, 1'b0, 64'h0, 64'h0);
        step();
        drive64(1'b0, 1'b0, 64'h0, 64'h0);
        compared++;
        if ({out_valid64, out_round64, out_last64, seq_err64} !== {1'b1, 5'd0, 1'b0, 1'b1}) begin
            mismatched++;
            $display("FAIL seq_err64 got vld=%b rnd=%0d last=%b err=%b want 1 0 0 1",
                     out_valid64, out_round64, out_last64, seq_err64);
        end
        step();
        drive64(1'b1, 1'b1, 64'h0, 64'h0);
        step();
        drive64(1'b0, 1'b0, 64'h0, 64'h0);
        compared++;
        if ({seq_err64, out_round64} !== {1'b1, 5'd31}) begin
            mismatched++;
            $display("FAIL seq_err64_sticky got err=%b rnd=%0d want 1 31", seq_err64, out_round64);
        end
        $display("seq_err64: err=%b", seq_err64);
        step();
    endtask

    // Scenario 4: three stalled cycles while feeding, then release.
    task automatic test_stall64();
        reset = 1'b1;
        step();
        reset = 1'b0;
        out_ready64 = 1'b0;
        drive64(1'b1, 1'b1, 64'h2, 64'h0);          // expect out 0x10
        step();
        drive64(1'b1, 1'b0, 64'h4, 64'h0);          // expect out 0x100
        compared++;
        if ({out_valid64, in_ready64, out_state64} !== {1'b1, 1'b1, 64'h10}) begin
            mismatched++;
            $display("FAIL stall64_first got vld=%b rdy=%b st=%h want 1 1 10", out_valid64, in_ready64, out_state64);
        end
        step();
        drive64(1'b1, 1'b0, 64'h0000_0000_0000_0010, 64'h0);  // expect out 0x10000
        compared++;
        if ({in_ready64, out_state64, out_round64} !== {1'b0, 64'h10, 5'd31}) begin
            mismatched++;
            $display("FAIL stall64_full got rdy=%b st=%h rnd=%0d want 0 10 31", in_ready64, out_state64, out_round64);
        end
        step();
        compared++;
        if ({out_valid64, in_ready64, out_state64, out_round64} !== {1'b1, 1'b0, 64'h10, 5'd31}) begin
            mismatched++;
            $display("FAIL stall64_hold got vld=%b rdy=%b st=%h rnd=%0d want 1 0 10 31",
                     out_valid64, in_ready64, out_state64, out_round64);
        end
        $display("stall64: held st=%h rdy=%b", out_state64, in_ready64);
        out_ready64 = 1'b1;
        step();
        compared++;
        if ({out_valid64, in_ready64, out_state64, out_round64} !== {1'b1, 1'b1, 64'h100, 5'd30}) begin
            mismatched++;
            $display("FAIL stall64_rel1 got vld=%b rdy=%b st=%h rnd=%0d want 1 1 100 30",
                     out_valid64, in_ready64, out_state64, out_round64);
        end
        step();
        drive64(1'b0, 1'b0, 64'h0, 64'h0);
        compared++;
        if ({out_valid64, out_state64, out_round64} !== {1'b1, 64'h10000, 5'd29}) begin
            mismatched++;
            $display("FAIL stall64_rel2 got vld=%b st=%h rnd=%0d want 1 10000 29",
                     out_valid64, out_state64, out_round64);
        end
        $display("stall64: released st=%h rnd=%0d", out_state64, out_round64);
        step();
        compared++;
        if (out_valid64 !== 1'b0) begin
            mismatched++;
            $display("FAIL stall64_empty got vld=%b want 0", out_valid64);
        end
    endtask

    // Scenario 5b: reset with both slots occupied.
    task automatic test_mid_reset64();
        out_ready64 = 1'b0;
        drive64(1'b1, 1'b1, 64'h2, 64'h0);
        step();
        drive64(1'b1, 1'b0, 64'h4, 64'h0);
        step();
        drive64(1'b0, 1'b0, 64'h0, 64'h0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        compared++;
        if ({in_ready64, out_valid64, out_state64, out_round64, out_last64, seq_err64} !==
            {1'b1, 1'b0, 64'h0, 5'd0, 1'b0, 1'b0}) begin
            mismatched++;
            $display("FAIL mid_reset64 got rdy=%b vld=%b st=%h rnd=%0d last=%b err=%b want 1 0 0 0 0 0",
                     in_ready64, out_valid64, out_state64, out_round64, out_last64, seq_err64);
        end
        out_ready64 = 1'b1;
        drive64(1'b1, 1'b0, 64'h0, 64'h0);
        step();
        drive64(1'b0, 1'b0, 64'h0, 64'h0);
        compared++;
        if ({out_valid64, out_round64, seq_err64} !== {1'b1, 5'd0, 1'b1}) begin
            mismatched++;
            $display("FAIL mid_reset64_cnt got vld=%b rnd=%0d err=%b want 1 0 1", out_valid64, out_round64, seq_err64);
        end
        $display("mid_reset64: err=%b", seq_err64);
        step();
    endtask

    // Scenario 6: single beat and a full block at SIZE=128.
    task automatic test_single128();
        out_ready128 = 1'b1;
        drive128(1'b1, 1'b1, 128'h1 << 32, 128'h0);
        step();
        drive128(1'b0, 1'b0, 128'h0, 128'h0);
        compared++;
        if ({out_valid128, out_state128, out_round128, out_last128} !== {1'b1, 128'h2, 5'd31, 1'b0}) begin
            mismatched++;
            $display("FAIL single128 got vld=%b st=%h rnd=%0d last=%b want 1 2 31 0",
                     out_valid128, out_state128, out_round128, out_last128);
        end
        $display("single128: st=%h rnd=%0d", out_state128, out_round128);
        step();
    endtask

    task automatic test_back_to_back128();
        out_ready128 = 1'b1;
        for (int k = 0; k < 31; k++) begin
            drive128(1'b1, (k == 0), 128'h0, 128'h2);
            step();
            compared++;
            if ({out_valid128, in_ready128, out_round128, out_last128, out_state128} !==
                {1'b1, 1'b1, 5'(31 - k), (k == 30), 128'h10}) begin
                mismatched++;
                $display("FAIL b2b128 beat %0d got vld=%b rdy=%b rnd=%0d last=%b st=%h want 1 1 %0d %b 10",
                         k, out_valid128, in_ready128, out_round128, out_last128, out_state128, 31 - k, (k == 30));
            end
            $display("b2b128 beat %0d: rnd=%0d last=%b", k, out_round128, out_last128);
        end
        drive128(1'b0, 1'b0, 128'h0, 128'h0);
        step();
    endtask

    initial begin
        reset = 1'b1;
        out_ready64 = 1'b1;
        out_ready128 = 1'b1;
        drive64(1'b0, 1'b0, 64'h0, 64'h0);
        drive128(1'b0, 1'b0, 128'h0, 128'h0);
        test_reset();
        test_single64();
        test_datapath64();
        test_back_to_back64();
        test_seq_err64();
        test_stall64();
        test_mid_reset64();
        test_reset();
        test_single128();
        test_back_to_back128();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
